// File: rtl/lfsr_timer_sched.sv
// Round-robin scheduler that lends one LFSR terminal-count counter to NREQ clients,
// loading the winner's seed, running until tercnt, and guarding with a watchdog.
module lfsr_timer_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int WDOG  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] seed,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic                  busy,
  output logic [WIDTH-1:0]      lfsr_data,
  output logic                  lfsr_load_n,
  output logic                  lfsr_cen,
  input  logic                  lfsr_tercnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (WDOG > 1) ? $clog2(WDOG) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, owner, pick, owner_next;
  logic            found;
  logic            err_nxt;
  logic            release_gnt;
  logic [WW-1:0]   wdog_cnt;
  logic [WIDTH-1:0] pick_seed;

  // Scan downward in offset so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    pick  = rr_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx  = (int'(rr_ptr) + i) % NREQ;
      cand = IW'(idx);
      if (req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    pick_seed  = seed[int'(pick)*WIDTH +: WIDTH];
    owner_next = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
  end

  always_comb begin
    state_nxt   = state;
    err_nxt     = 1'b0;
    release_gnt = 1'b0;
    unique case (state)
      IDLE: if (found) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN: begin
        if (!req[owner]) begin
          state_nxt   = IDLE;
          release_gnt = 1'b1;
        end else if (lfsr_tercnt) begin
          state_nxt = DONE;
        end else if (wdog_cnt == WW'(WDOG - 1)) begin
          state_nxt   = IDLE;
          err_nxt     = 1'b1;
          release_gnt = 1'b1;
        end
      end
      DONE: begin
        state_nxt   = IDLE;
        release_gnt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter enable follows tercnt combinationally so the counter parks on the terminal state.
  always_comb begin
    busy        = (state != IDLE);
    lfsr_load_n = (state != LOAD);
    lfsr_cen    = (state == RUN) && !lfsr_tercnt;
    done        = (state == DONE) ? gnt : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= '0;
      err       <= 1'b0;
      lfsr_data <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      wdog_cnt  <= '0;
    end else begin
      state <= state_nxt;
      err   <= err_nxt;
      if (state == IDLE && found) begin
        gnt       <= NREQ'(1) << pick;
        owner     <= pick;
        lfsr_data <= pick_seed;
      end
      // Every exit moves the pointer past the owner so a stuck client cannot starve others.
      if (release_gnt) begin
        gnt    <= '0;
        rr_ptr <= owner_next;
      end
      if (state == LOAD) wdog_cnt <= '0;
      else if (state == RUN) wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_timer_sched.sv
// Directed plus randomized checks of lfsr_timer_sched against a seed-to-duration
// reference model, with a simple down-counter standing in for the LFSR counter.
module tb_lfsr_timer_sched;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int WDOG  = 16;
  localparam int SW    = NREQ * WIDTH;

  logic             clk;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic [SW-1:0]    seed;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  done;
  logic             err;
  logic             busy;
  logic [WIDTH-1:0] lfsr_data;
  logic             lfsr_load_n;
  logic             lfsr_cen;
  logic             lfsr_tercnt;

  logic             tercnt_stuck;
  logic [WIDTH-1:0] cnt = '0;

  int compared   = 0;
  int mismatched = 0;
  int rr         = 0;

  lfsr_timer_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .WDOG(WDOG)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .seed(seed),
    .gnt(gnt),
    .done(done),
    .err(err),
    .busy(busy),
    .lfsr_data(lfsr_data),
    .lfsr_load_n(lfsr_load_n),
    .lfsr_cen(lfsr_cen),
    .lfsr_tercnt(lfsr_tercnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in counter: a seed of s reaches the terminal value (zero) after s enabled cycles.
  always @(posedge clk) begin
    if (!lfsr_load_n) cnt <= lfsr_data;
    else if (lfsr_cen && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign lfsr_tercnt = !tercnt_stuck && (cnt == '0);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_ref(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_gnt"}, 32'(gnt), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_err"}, 32'(err), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_load_n"}, 32'(lfsr_load_n), 32'd1);
    check_output({tag, "_cen"}, 32'(lfsr_cen), 32'd0);
  endtask

  // Called in the LOAD cycle; returns in the first IDLE cycle after the service.
  task automatic apply_stimulus(input int o, input int s, input bit stuck,
                                input int abort_k, input bit jitter);
    int  n;
    bit  aborted;
    logic [NREQ-1:0] own;
    own     = NREQ'(1) << o;
    n       = stuck ? WDOG : s + 1;
    aborted = 1'b0;
    check_output("load_gnt", 32'(gnt), 32'(own));
    check_output("load_n", 32'(lfsr_load_n), 32'd0);
    check_output("load_cen", 32'(lfsr_cen), 32'd0);
    check_output("load_data", 32'(lfsr_data), 32'(s));
    check_output("load_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= n && !aborted; k++) begin
      step;
      check_output("run_gnt", 32'(gnt), 32'(own));
      check_output("run_load_n", 32'(lfsr_load_n), 32'd1);
      check_output("run_done", 32'(done), 32'd0);
      check_output("run_err", 32'(err), 32'd0);
      check_output("run_data", 32'(lfsr_data), 32'(s));
      if (abort_k == k) begin
        req[o]  = 1'b0;
        aborted = 1'b1;
      end else begin
        check_output("run_cen", 32'(lfsr_cen), (stuck || k < n) ? 32'd1 : 32'd0);
        if (jitter) begin
          req  = (NREQ'($urandom) & ~own) | own;
          seed = SW'($urandom);
        end
      end
    end
    step;
    if (aborted) begin
      check_idle_outputs("abort");
    end else if (stuck) begin
      check_output("wdog_err", 32'(err), 32'd1);
      check_output("wdog_gnt", 32'(gnt), 32'd0);
      check_output("wdog_busy", 32'(busy), 32'd0);
      check_output("wdog_done", 32'(done), 32'd0);
    end else begin
      check_output("done_pulse", 32'(done), 32'(own));
      check_output("done_gnt", 32'(gnt), 32'(own));
      check_output("done_err", 32'(err), 32'd0);
      check_output("done_cen", 32'(lfsr_cen), 32'd0);
      step;
      check_output("post_gnt", 32'(gnt), 32'd0);
      check_output("post_done", 32'(done), 32'd0);
      check_output("post_busy", 32'(busy), 32'd0);
    end
    rr = (o + 1) % NREQ;
  endtask

  initial begin
    int o, s, ab;
    reset        = 1'b0;
    tercnt_stuck = 1'b0;
    req          = '0;
    seed         = '0;
    step;
    step;
    check_idle_outputs("reset");
    check_output("reset_data", 32'(lfsr_data), 32'd0);
    reset = 1'b1;

    $display("[TB] round-robin with req=1011 held");
    req  = 4'b1011;
    seed = {4'd2, 4'd7, 4'd5, 4'd3};
    for (int i = 0; i < 4; i++) begin
      step;
      o = pick_ref(req, rr);
      s = int'(seed[o*WIDTH +: WIDTH]);
      apply_stimulus(o, s, 1'b0, 0, 1'b0);
    end
    req = '0;

    $display("[TB] single request, seed 1");
    req = 4'b0010;
    seed[1*WIDTH +: WIDTH] = 4'd1;
    step;
    apply_stimulus(pick_ref(req, rr), 1, 1'b0, 0, 1'b0);
    req = '0;

    $display("[TB] abort in third RUN cycle, then next requester");
    req = 4'b0110;
    seed[2*WIDTH +: WIDTH] = 4'd10;
    seed[1*WIDTH +: WIDTH] = 4'd5;
    step;
    apply_stimulus(pick_ref(req, rr), 10, 1'b0, 3, 1'b0);
    step;
    apply_stimulus(pick_ref(req, rr), 5, 1'b0, 0, 1'b0);
    req = '0;

    $display("[TB] seed equal to terminal value");
    req = 4'b0001;
    seed[0 +: WIDTH] = 4'd0;
    step;
    apply_stimulus(pick_ref(req, rr), 0, 1'b0, 0, 1'b0);
    req = '0;

    $display("[TB] longest legal seed finishes on the last watchdog cycle");
    req = 4'b1000;
    seed[3*WIDTH +: WIDTH] = 4'd15;
    step;
    apply_stimulus(pick_ref(req, rr), 15, 1'b0, 0, 1'b0);
    req = '0;

    $display("[TB] watchdog with tercnt stuck low");
    tercnt_stuck = 1'b1;
    req = 4'b0100;
    seed[2*WIDTH +: WIDTH] = 4'd7;
    step;
    apply_stimulus(pick_ref(req, rr), 7, 1'b1, 0, 1'b0);
    req = '0;
    tercnt_stuck = 1'b0;

    $display("[TB] randomized services");
    for (int it = 0; it < 24; it++) begin
      req  = NREQ'($urandom_range(1, 15));
      seed = SW'($urandom);
      o    = pick_ref(req, rr);
      s    = int'(seed[o*WIDTH +: WIDTH]);
      ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, s + 1)) : 0;
      step;
      apply_stimulus(o, s, 1'b0, ab, 1'b1);
    end
    req = '0;
    step;

    $display("[TB] asynchronous reset mid-RUN");
    req = 4'b1000;
    seed[3*WIDTH +: WIDTH] = 4'd9;
    step;
    step;
    step;
    check_output("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    check_output("async_reset_data", 32'(lfsr_data), 32'd0);
    rr  = 0;
    req = 4'b0100;
    seed[2*WIDTH +: WIDTH] = 4'd4;
    step;
    step;
    reset = 1'b1;
    step;
    apply_stimulus(pick_ref(req, rr), 4, 1'b0, 0, 1'b0);
    req = '0;
    step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lfsr_timer_sched.md
Name: lfsr_timer_sched

Overview:
- Schedules one shared LFSR terminal-count counter among NREQ requesters. The counter is the team's load/cen/tercnt LFSR counter (active-low load, active-high count enable).
- Each requester asks for a timed interval by supplying an LFSR seed. The block picks one requester round-robin, loads that seed into the counter, enables counting, and pulses done to the owner when tercnt rises.
- A watchdog catches seeds that never reach the terminal state.
- Sits between the timer clients and the single counter instance.

Parameters:
- WIDTH, 8, LFSR counter width; width of each seed.
- NREQ, 4, number of requesters (2..16).
- WDOG, 256, maximum RUN cycles before abort (must be ≥ 2^WIDTH - 1 for a legal seed to complete).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester level request; must stay high until done or err.
- seed  in  NREQ*WIDTH  packed seeds; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot owner of the counter; all zero when idle.
- done  out  NREQ  one-cycle pulse to the owner when its interval expires.
- err  out  1  one-cycle pulse when the watchdog fires.
- busy  out  1  high in any state other than IDLE.
- lfsr_data  out  WIDTH  seed to the counter data input.
- lfsr_load_n  out  1  active-low load to the counter.
- lfsr_cen  out  1  count enable to the counter.
- lfsr_tercnt  in  1  terminal-count flag from the counter.

Behaviour:
- Reset values: state=IDLE; gnt=0; done=0; err=0; busy=0; lfsr_load_n=1; lfsr_cen=0; lfsr_data=0; rr_ptr=0; wdog_cnt=0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req bit is high, grant the first set bit searching upward from rr_ptr, wrapping at NREQ.
  - Register the one-hot gnt, capture the winner's seed into lfsr_data, then go to LOAD.
  - Grant appears 1 cycle after req is sampled.
- LOAD (exactly 1 cycle):
  - lfsr_load_n=0, lfsr_cen=0; clear wdog_cnt; then go to RUN.
- RUN:
  - lfsr_load_n=1.
  - lfsr_cen = ~lfsr_tercnt. This is a combinational path, so the counter never advances past the terminal state.
  - wdog_cnt increments every cycle.
  - Exits are checked in priority order:
    - If req[owner]=0: abort. gnt clears next cycle, lfsr_cen=0, go to IDLE with no done or err.
    - Else if lfsr_tercnt=1: go to DONE.
    - Else if wdog_cnt = WDOG-1: pulse err, clear gnt, go to IDLE.
- DONE (1 cycle):
  - done[owner]=1, gnt still asserted, lfsr_cen=0.
  - Next cycle: gnt=0, rr_ptr = (owner+1) mod NREQ, go to IDLE.
- rr_ptr advances on done, err and abort alike, so a stuck client cannot starve the others.
- Back-to-back operation: a new grant may be issued in the first IDLE cycle after DONE. Minimum service time is 4 cycles (IDLE, LOAD, RUN, DONE).
- Seed equal to the terminal value: tercnt is high in the first RUN cycle, so the block passes through RUN→DONE with zero count-enabled cycles.
- Req edges:
  - A req rising on a non-owner during a service is held off until IDLE.
  - A req dropping on a non-owner has no effect.
- Seed is sampled only in IDLE on grant; later seed changes are ignored.
- Asynchronous reset mid-operation returns every output to its reset value immediately. Nothing is held pending.
- Invariants:
  - gnt is always zero or one-hot.
  - done is a subset of gnt.
  - done and err are never high together.

Test Plan:
- Single request (NREQ=4, WIDTH=8, counter count_to=8): req=4'b0010 with seed 1 at cycle 0.
  - gnt=0010 at cycle 1.
  - lfsr_load_n=0 only in cycle 2.
  - lfsr_cen high until tercnt.
  - done=0010 for exactly one cycle.
  - gnt=0 on the next cycle.
- Round-robin: req=4'b1011 held.
  - Grants in order 0001, 0010, 1000, 0001.
  - Each grant is preceded by the previous owner's done pulse.
- Abort: owner drops req in the 3rd RUN cycle.
  - gnt=0 and lfsr_cen=0 next cycle, no done, no err.
  - The next requester is granted from IDLE.
- Watchdog: WDOG=16, lfsr_tercnt tied low.
  - err pulses after 16 RUN cycles, gnt clears, busy falls.
- Seed equals the terminal value (tercnt high right after load).
  - One RUN cycle with lfsr_cen=0, then done.
  - Total of 4 cycles from grant to idle.
- Reset mid-RUN: assert reset low asynchronously.
  - All outputs at reset values before the next clk edge.
  - After release, req=0100 is granted with rr_ptr=0 ordering.
